// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file write-back pulse
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            wb_wen,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              bzero_q, bzero_d, ovf_q, ovf_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic              wb_wen_q, wb_wen_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    // Operand decode at start: which operands are signed, magnitudes and special-case flags
    logic            sgn_a, sgn_b, sa_in, sb_in, is_mul_in;
    logic [XLEN-1:0] abs_a, abs_b;
    assign is_mul_in = ~funct3[2];
    assign sgn_a     = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign sgn_b     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sa_in     = sgn_a & rs1_data[XLEN-1];
    assign sb_in     = sgn_b & rs2_data[XLEN-1];
    assign abs_a     = sa_in ? -rs1_data : rs1_data;
    assign abs_b     = sb_in ? -rs2_data : rs2_data;

    // Radix-2 step datapath: multiplier lives in prod low half, dividend/quotient likewise
    logic [XLEN:0] mul_sum, div_shift, div_trial;
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb_q};

    // Final sign fix and special-case override, consumed in FIN
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   quo_s, rem_s, result;
    assign mul_full = (sa_q ^ sb_q) ? -prod_q : prod_q;
    assign quo_s    = (sa_q ^ sb_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_s    = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    // Result selection by operation
    always_comb begin
        result = '0;
        case (op_q)
            3'b000:                 result = mul_full[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = mul_full[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = bzero_q ? '1 : (ovf_q ? MIN_VAL : quo_s);
            default:                result = ovf_q ? '0 : rem_s;
        endcase
    end

    // Next-state and datapath update for the IDLE/CALC/FIN sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        bzero_d   = bzero_q;
        ovf_d     = ovf_q;
        opb_d     = opb_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        wb_wen_d  = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = funct3;
                    rd_d    = rd_addr_in;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    bzero_d = (rs2_data == '0);
                    ovf_d   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                              (rs1_data == MIN_VAL) && (rs2_data == '1);
                    opb_d   = is_mul_in ? abs_a : abs_b;
                    prod_d  = {{XLEN{1'b0}}, (is_mul_in ? abs_b : abs_a)};
                    rem_d   = '0;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (!op_q[2]) begin
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    end else begin
                        rem_d  = div_trial[XLEN] ? div_shift : div_trial;
                        prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], ~div_trial[XLEN]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    wb_wen_d  = 1'b1;
                    wb_addr_d = rd_q;
                    wb_data_d = result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            opb_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            wb_wen_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            bzero_q   <= bzero_d;
            ovf_q     <= ovf_d;
            opb_q     <= opb_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            wb_wen_q  <= wb_wen_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign wb_wen  = wb_wen_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
endmodule
